// File: rtl/prog_loader.sv
// prog_loader: streams host headers/words into node instr_rams and sequences the broadcast node reset/clk_en.
// Optional PROG_LOADER_CLEAR_EN: NOP-fills the addresses after the last loaded word.
module prog_loader #(
  parameter int NUM_NODES = 4,
  parameter int ADDR_W    = 5,
  parameter int INSTR_W   = 21
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_data,
  output logic [NUM_NODES-1:0] wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [INSTR_W-1:0]   wr_data,
  output logic                 node_reset,
  output logic                 node_clk_en,
  output logic                 busy
);
  localparam int NODE_W = NUM_NODES > 1 ? $clog2(NUM_NODES) : 1;
  localparam int SEL_W = INSTR_W - 10;
  localparam logic [SEL_W-1:0] NODE_LIM = SEL_W'(NUM_NODES);
  typedef enum logic [2:0] {S_HALT, S_LOAD, S_FILL, S_RST, S_RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, last_q, last_d, wr_addr_q, wr_addr_d;
  logic [NODE_W-1:0] node_q, node_d;
  logic ok_q, ok_d, accept;
  logic [NUM_NODES-1:0] wr_en_q, wr_en_d, sel;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic in_ready_q, node_reset_q, node_clk_en_q, busy_q;
  logic [1:0] cmd;
  assign accept = in_valid & in_ready_q;
  assign cmd = in_data[INSTR_W-1 -: 2];
  always_comb begin
    sel = '0;
    sel[node_q] = ok_q;
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    node_d    = node_q;
    ok_d      = ok_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_HALT, S_RUN: if (accept) begin
        if (cmd == 2'b00) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          last_d  = in_data[ADDR_W-1:0];
          node_d  = in_data[NODE_W+7:8];
          // validity uses the whole field up to cmd so out-of-range indices are caught
          ok_d    = in_data[INSTR_W-3:8] < NODE_LIM;
        end else if (cmd == 2'b01) state_d = S_RST;
        else if (cmd == 2'b10) state_d = S_HALT;
      end
      S_LOAD: if (accept) begin
        wr_en_d   = sel;
        wr_addr_d = cnt_q;
        wr_data_d = in_data;
        cnt_d     = cnt_q + 1'b1;
`ifdef PROG_LOADER_CLEAR_EN
        if (cnt_q == last_q) state_d = &last_q ? S_HALT : S_FILL;
`else
        if (cnt_q == last_q) state_d = S_HALT;
`endif
      end
`ifdef PROG_LOADER_CLEAR_EN
      S_FILL: begin
        wr_en_d   = sel;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        cnt_d     = cnt_q + 1'b1;
        state_d   = &cnt_q ? S_HALT : S_FILL;
      end
`endif
      S_RST:   state_d = S_RUN;
      default: state_d = S_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_HALT;
      cnt_q         <= '0;
      last_q        <= '0;
      node_q        <= '0;
      ok_q          <= 1'b0;
      wr_en_q       <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      in_ready_q    <= 1'b0;
      node_reset_q  <= 1'b0;
      node_clk_en_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      node_q        <= node_d;
      ok_q          <= ok_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      in_ready_q    <= !(state_d inside {S_RST, S_FILL});
      node_reset_q  <= state_d == S_RST;
      node_clk_en_q <= state_d == S_RUN;
      busy_q        <= state_d inside {S_LOAD, S_FILL, S_RST};
    end
  end
  assign in_ready    = in_ready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign node_reset  = node_reset_q;
  assign node_clk_en = node_clk_en_q;
  assign busy        = busy_q;
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Sequences the instruction RAMs of NUM_NODES TIS-100 nodes.
- Accepts a valid/ready word stream of command headers and instruction words from the host link and writes each program into the selected node's instr_ram (write_en/write_addr/write_data).
- Drives a broadcast node reset and clock-enable, so nodes run only after loading finishes and halt whenever a reload begins.
- Sits between the host UART/word deserializer and the node array.

Parameters:
- NUM_NODES, 4, number of nodes driven; node index width NODE_W = $clog2(NUM_NODES), minimum 1.
- ADDR_W, 5, instr_ram address width (32 instructions).
- INSTR_W, 21, instruction word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  host word valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  INSTR_W  header or instruction word.
- wr_en  out  NUM_NODES  one-hot instr_ram write_en.
- wr_addr  out  ADDR_W  shared write_addr.
- wr_data  out  INSTR_W  shared write_data.
- node_reset  out  1  broadcast node reset (PC/acc clear).
- node_clk_en  out  1  broadcast node clk_en.
- busy  out  1  high in LOAD/FILL/RST.

Behaviour:
- Handshake: a word transfers on a cycle with in_valid & in_ready. All outputs are registered.
- Reset: state=HALT; wr_en=0, wr_addr=0, wr_data=0, node_reset=0, node_clk_en=0, busy=0, in_ready=0 on the reset cycle and 1 from the next cycle. Reset in any state aborts the operation; a partial load is not completed.
- Header fields:
  - [20:19] cmd: 00 LOAD, 01 RUN, 10 HALT, 11 reserved (consumed, ignored).
  - [NODE_W+7:8] node.
  - [ADDR_W-1:0] last (word count minus 1, 1..32 words).
- HALT state: node_clk_en=0, in_ready=1.
  - LOAD goes to LOAD with addr counter=0 and latches node and last.
  - RUN goes to RST.
  - HALT stays in HALT.
- LOAD state: in_ready=1.
  - Each accepted word at cycle t gives wr_en[node]=1, wr_addr=counter, wr_data=word at t+1; the counter then increments.
  - Accepting the word with counter==last goes to HALT (or FILL, see Optional Feature).
  - Node >= NUM_NODES: words are consumed and counted, but wr_en stays 0.
  - Stalls (in_valid=0) hold state indefinitely.
- RST state: in_ready=0; node_reset=1 for exactly one cycle, node_clk_en=0; then RUN.
- RUN state: node_clk_en=1, in_ready=1.
  - LOAD header goes to LOAD; node_clk_en=0 from the cycle after acceptance, before any wr_en.
  - HALT header goes to HALT with node_clk_en=0 the next cycle.
  - RUN header goes to RST (restart).
- wr_en is never asserted while node_clk_en=1. It is one-hot or zero, and high for one cycle per accepted word.
- Counter wraps modulo 2^ADDR_W. last=31 writes addresses 0..31.

Optional Feature:
- Macro PROG_LOADER_CLEAR_EN.
- Defined: after the last payload word, enter FILL with in_ready=0. FILL writes wr_data=0 (NOP) to addresses last+1..31 on the same node, one per cycle, then goes to HALT. If last==31, FILL is skipped. Invalid node: FILL runs with wr_en=0.
- Undefined: no FILL state; unwritten addresses keep old contents; HALT follows the last word directly.

Test Plan:
- Reset, then LOAD node 2 last=2 with words 21'h00011, 21'h00022, 21'h00033 back-to-back -> wr_en=4'b0100 on three consecutive cycles, addr 0,1,2, data as sent; node_clk_en stays 0; returns to HALT, in_ready=1.
- LOAD node 0 last=1 with in_valid gaps of 3 cycles between words -> exactly two writes (addr 0,1), no spurious wr_en during gaps.
- RUN header from HALT -> node_reset=1 for one cycle, next cycle node_clk_en=1, busy=0; in_ready=0 during RST.
- While RUN, LOAD node 1 last=0 word 21'h1ABCD -> node_clk_en=0 on the cycle after header acceptance, then wr_en=4'b0010 addr 0; after a RUN header, node_reset pulses, then node_clk_en=1.
- LOAD node 5 (NUM_NODES=4) last=3 -> four words consumed, wr_en stays 0; assert reset mid-LOAD of a valid node after 1 word -> all outputs 0 next cycle; the next word is treated as a header.
- With PROG_LOADER_CLEAR_EN: LOAD node 3 last=29 -> after 30 payload writes, addr 30 and 31 are written with 0, in_ready=0 for 2 cycles, then HALT.
